// File: rtl/jtag_tap_datapath.sv
// IR/DR capture-shift-update datapath driven by one-hot TAP state strobes.
// Provides IDCODE, BYPASS and USER data registers and an ABORT pulse.
module jtag_tap_datapath #(
  parameter int unsigned          IR_WIDTH     = 4,
  parameter logic [31:0]          IDCODE_VALUE = 32'h000F_AF01,
  parameter int unsigned          USER_WIDTH   = 8,
  parameter logic [IR_WIDTH-1:0]  IR_CAPTURE   = IR_WIDTH'(4'b0101)
) (
  input  logic                  tck_i,
  input  logic                  trst_ni,
  input  logic                  enable_i,
  input  logic                  tdi_i,
  input  logic                  tlr_i,
  input  logic                  capture_ir_i,
  input  logic                  shift_ir_i,
  input  logic                  update_ir_i,
  input  logic                  capture_dr_i,
  input  logic                  shift_dr_i,
  input  logic                  update_dr_i,
  output logic                  tdo_o,
  output logic                  tdo_en_o,
  output logic [IR_WIDTH-1:0]   ir_value_o,
  output logic [USER_WIDTH-1:0] user_reg_o,
  output logic                  user_update_o,
  output logic                  abort_pulse_o
);

  localparam logic [IR_WIDTH-1:0] IrAbort  = IR_WIDTH'(4'b1000);
  localparam logic [IR_WIDTH-1:0] IrIdcode = IR_WIDTH'(4'b1110);
  localparam logic [IR_WIDTH-1:0] IrUser   = IR_WIDTH'(4'b0100);

  typedef enum logic [1:0] {SelBypass, SelIdcode, SelUser} dr_sel_e;

  logic [IR_WIDTH-1:0]   ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic [31:0]           dr_q, dr_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic                  tdo_q, tdo_d;
  logic                  tdo_en_q, tdo_en_d;
  logic                  user_upd_q, user_upd_d;
  logic                  abort_q, abort_d;
  dr_sel_e               dr_sel;

  // ABORT and unknown codes fall through to the 1-bit bypass register.
  always_comb begin
    if (ir_q == IrIdcode)    dr_sel = SelIdcode;
    else if (ir_q == IrUser) dr_sel = SelUser;
    else                     dr_sel = SelBypass;
  end

  always_comb begin
    ir_sr_d    = ir_sr_q;
    ir_d       = ir_q;
    dr_d       = dr_q;
    user_d     = user_q;
    tdo_d      = tdo_q;
    user_upd_d = 1'b0;
    abort_d    = 1'b0;
    tdo_en_d   = (shift_ir_i | shift_dr_i) & enable_i;

    if (enable_i) begin
      tdo_d = 1'b0;
      if (tlr_i) begin
        ir_d = IrIdcode;
      end else if (update_ir_i) begin
        ir_d    = ir_sr_q;
        abort_d = (ir_sr_q == IrAbort);
      end else if (capture_ir_i) begin
        ir_sr_d = IR_CAPTURE;
      end else if (shift_ir_i) begin
        ir_sr_d = {tdi_i, ir_sr_q[IR_WIDTH-1:1]};
        tdo_d   = ir_sr_q[0];
      end else if (update_dr_i) begin
        if (dr_sel == SelUser) begin
          user_d     = dr_q[USER_WIDTH-1:0];
          user_upd_d = 1'b1;
        end
      end else if (capture_dr_i) begin
        unique case (dr_sel)
          SelIdcode: dr_d = IDCODE_VALUE;
          SelUser:   dr_d = 32'(user_q);
          default:   dr_d[0] = 1'b0;
        endcase
      end else if (shift_dr_i) begin
        tdo_d = dr_q[0];
        dr_d  = {1'b0, dr_q[31:1]};
        // tdi enters at the top of the selected register's length.
        unique case (dr_sel)
          SelIdcode: dr_d[31] = tdi_i;
          SelUser:   dr_d[USER_WIDTH-1] = tdi_i;
          default:   dr_d[0] = tdi_i;
        endcase
      end
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_sr_q    <= '0;
      ir_q       <= IrIdcode;
      dr_q       <= '0;
      user_q     <= '0;
      tdo_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
      user_upd_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      ir_sr_q    <= ir_sr_d;
      ir_q       <= ir_d;
      dr_q       <= dr_d;
      user_q     <= user_d;
      tdo_q      <= tdo_d;
      tdo_en_q   <= tdo_en_d;
      user_upd_q <= user_upd_d;
      abort_q    <= abort_d;
    end
  end

  assign tdo_o         = tdo_q;
  assign tdo_en_o      = tdo_en_q;
  assign ir_value_o    = ir_q;
  assign user_reg_o    = user_q;
  assign user_update_o = user_upd_q;
  assign abort_pulse_o = abort_q;

endmodule

// File: tb/tb_jtag_tap_datapath.sv
// Directed bench for jtag_tap_datapath: IDCODE, BYPASS, USER, ABORT, freeze,
// TLR and mid-scan reset, with hand-computed expectations.
module tb_jtag_tap_datapath;

  logic       tck = 1'b0;
  logic       trst_n;
  logic       enable;
  logic       tdi;
  logic       tlr;
  logic       capture_ir, shift_ir, update_ir;
  logic       capture_dr, shift_dr, update_dr;
  logic       tdo, tdo_en, user_update, abort_pulse;
  logic [3:0] ir_value;
  logic [7:0] user_reg;

  int checks = 0;
  int errors = 0;

  logic [31:0] dout;
  logic [3:0]  iout;
  int          en_cnt;

  always #5 tck = ~tck;

  jtag_tap_datapath dut (
    .tck_i         (tck),
    .trst_ni       (trst_n),
    .enable_i      (enable),
    .tdi_i         (tdi),
    .tlr_i         (tlr),
    .capture_ir_i  (capture_ir),
    .shift_ir_i    (shift_ir),
    .update_ir_i   (update_ir),
    .capture_dr_i  (capture_dr),
    .shift_dr_i    (shift_dr),
    .update_dr_i   (update_dr),
    .tdo_o         (tdo),
    .tdo_en_o      (tdo_en),
    .ir_value_o    (ir_value),
    .user_reg_o    (user_reg),
    .user_update_o (user_update),
    .abort_pulse_o (abort_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic ir_scan(input logic [3:0] din, output logic [3:0] out);
    out = '0;
    capture_ir = 1'b1;
    tick();
    capture_ir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      shift_ir = 1'b1;
      tdi      = din[i];
      tick();
      out[i] = tdo;
    end
    shift_ir  = 1'b0;
    update_ir = 1'b1;
    tick();
    update_ir = 1'b0;
  endtask

  task automatic dr_scan(input int len, input logic [31:0] din, input bit do_update,
                         output logic [31:0] out, output int ens);
    out = '0;
    ens = 0;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    for (int i = 0; i < len; i++) begin
      shift_dr = 1'b1;
      tdi      = din[i];
      tick();
      out[i] = tdo;
      ens += int'(tdo_en);
    end
    shift_dr = 1'b0;
    if (do_update) begin
      update_dr = 1'b1;
      tick();
      update_dr = 1'b0;
    end
  endtask

  initial begin
    trst_n = 1'b0; enable = 1'b1; tdi = 1'b0; tlr = 1'b0;
    capture_ir = 1'b0; shift_ir = 1'b0; update_ir = 1'b0;
    capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;

    tick();
    check("rst_ir", 32'(ir_value), 32'hE);
    check("rst_tdo", 32'(tdo), 32'h0);
    check("rst_tdo_en", 32'(tdo_en), 32'h0);
    check("rst_user", 32'(user_reg), 32'h0);
    check("rst_user_upd", 32'(user_update), 32'h0);
    check("rst_abort", 32'(abort_pulse), 32'h0);
    trst_n = 1'b1;
    tick();

    // IDCODE readout
    dr_scan(32, 32'h0, 1'b0, dout, en_cnt);
    check("idcode_stream", dout, 32'h000F_AF01);
    check("idcode_first_bit", 32'(dout[0]), 32'h1);
    check("idcode_en_cycles", 32'(en_cnt), 32'd32);
    tick();
    check("idle_tdo_en", 32'(tdo_en), 32'h0);

    // IR scan to BYPASS: captured 0101 shifts out LSB first
    ir_scan(4'hF, iout);
    check("ir_capture_out", 32'(iout), 32'h5);
    check("ir_bypass", 32'(ir_value), 32'hF);
    check("ir_bypass_no_abort", 32'(abort_pulse), 32'h0);

    // tdi 1,0,1,1 -> tdo 0,1,0,1
    dr_scan(4, 32'b1101, 1'b0, dout, en_cnt);
    check("bypass_stream", dout, 32'b1010);

    // USER write
    ir_scan(4'h4, iout);
    check("ir_user", 32'(ir_value), 32'h4);
    dr_scan(8, 32'hA5, 1'b1, dout, en_cnt);
    check("user_write", 32'(user_reg), 32'hA5);
    check("user_upd_hi", 32'(user_update), 32'h1);
    tick();
    check("user_upd_lo", 32'(user_update), 32'h0);

    // USER readback
    dr_scan(8, 32'h0, 1'b0, dout, en_cnt);
    check("user_readback", dout, 32'hA5);

    // USER scan with enable dropped for two cycles after bit 2
    dout = '0;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      shift_dr = 1'b1;
      tdi      = 1'(8'h3C >> i);
      tick();
      dout[i] = tdo;
    end
    enable = 1'b0;
    tdi    = 1'b1;
    tick();
    check("freeze_tdo_en", 32'(tdo_en), 32'h0);
    tick();
    enable = 1'b1;
    for (int i = 3; i < 8; i++) begin
      tdi = 1'(8'h3C >> i);
      tick();
      dout[i] = tdo;
    end
    shift_dr  = 1'b0;
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    check("freeze_stream", dout, 32'hA5);
    check("freeze_user", 32'(user_reg), 32'h3C);

    // ABORT: shift 1000 LSB first
    ir_scan(4'h8, iout);
    check("ir_abort", 32'(ir_value), 32'h8);
    check("abort_hi", 32'(abort_pulse), 32'h1);
    tick();
    check("abort_lo", 32'(abort_pulse), 32'h0);
    dr_scan(4, 32'b1101, 1'b0, dout, en_cnt);
    check("abort_bypass_stream", dout, 32'b1010);

    // TLR preserves user_reg
    ir_scan(4'hF, iout);
    check("ir_bypass2", 32'(ir_value), 32'hF);
    tlr = 1'b1;
    tick();
    tlr = 1'b0;
    check("tlr_ir", 32'(ir_value), 32'hE);
    check("tlr_user", 32'(user_reg), 32'h3C);

    // Asynchronous reset at IDCODE shift bit 10
    dr_scan(10, 32'h0, 1'b0, dout, en_cnt);
    shift_dr = 1'b1;
    check("pre_rst_tdo_en", 32'(tdo_en), 32'h1);
    #1;
    trst_n = 1'b0;
    #1;
    check("midrst_ir", 32'(ir_value), 32'hE);
    check("midrst_tdo", 32'(tdo), 32'h0);
    check("midrst_tdo_en", 32'(tdo_en), 32'h0);
    check("midrst_user", 32'(user_reg), 32'h0);
    shift_dr = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
